// File: rtl/uart_port_controller.sv
// Byte-wide UART handshake sequencer for the memory stage: drives the
// rdn/wrn strobes and the shared bus low byte, and synchronizes the UART
// status flags for status-register reads.
module uart_port_controller #(
    parameter int unsigned WR_PULSE_CYCLES = 2,
    parameter int unsigned RD_PULSE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       tx_ready,
    output logic       rx_ready,
    input  logic       data_ready,
    input  logic       tbre,
    input  logic       tsre,
    output logic       rdn,
    output logic       wrn,
    output logic       bus_oe,
    output logic [7:0] bus_out,
    input  logic [7:0] bus_in
);

    localparam int unsigned CNT_W         = 4;
    localparam int unsigned SETTLE_CYCLES = 2;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR_SETUP  = 4'd1;
    localparam logic [3:0] S_WR_PULSE  = 4'd2;
    localparam logic [3:0] S_WR_HOLD   = 4'd3;
    localparam logic [3:0] S_WR_SETTLE = 4'd4;
    localparam logic [3:0] S_WR_WAIT   = 4'd5;
    localparam logic [3:0] S_RD_WAIT   = 4'd6;
    localparam logic [3:0] S_RD_PULSE  = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    logic [3:0]       r_state;
    logic [3:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_bus_out;
    logic [7:0]       w_bus_out_nxt;
    logic [7:0]       r_rd_data;
    logic [7:0]       w_rd_data_nxt;
    logic             r_rdn;
    logic             r_wrn;
    logic             r_bus_oe;
    logic             r_busy;
    logic             r_done;

    logic             r_dr_m;
    logic             r_tbre_m;
    logic             r_tsre_m;
    logic             r_dr_s;
    logic             r_tbre_s;
    logic             r_tsre_s;
    logic             w_tx_ready;

    assign w_tx_ready = r_tbre_s & r_tsre_s;

    // Two-flop synchronizers for the asynchronous UART status flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_dr_m   <= 1'b0;
            r_tbre_m <= 1'b0;
            r_tsre_m <= 1'b0;
            r_dr_s   <= 1'b0;
            r_tbre_s <= 1'b0;
            r_tsre_s <= 1'b0;
        end else begin
            r_dr_m   <= data_ready;
            r_tbre_m <= tbre;
            r_tsre_m <= tsre;
            r_dr_s   <= r_dr_m;
            r_tbre_s <= r_tbre_m;
            r_tsre_s <= r_tsre_m;
        end
    end

    // State register; strobes and status are registered from the next state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bus_out <= 8'h00;
            r_rd_data <= 8'h00;
            r_rdn     <= 1'b1;
            r_wrn     <= 1'b1;
            r_bus_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bus_out <= w_bus_out_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_rdn     <= (w_state_nxt != S_RD_PULSE);
            r_wrn     <= (w_state_nxt != S_WR_PULSE);
            r_bus_oe  <= (w_state_nxt == S_WR_SETUP) || (w_state_nxt == S_WR_PULSE) ||
                         (w_state_nxt == S_WR_HOLD);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    // Next-state, counter and data-capture logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bus_out_nxt = r_bus_out;
        w_rd_data_nxt = r_rd_data;
        case (r_state)
            S_IDLE: begin
                if (rd_req) begin
                    w_state_nxt = S_RD_WAIT;
                end else if (wr_req) begin
                    w_state_nxt   = S_WR_SETUP;
                    w_bus_out_nxt = wr_data;
                end
            end
            S_WR_SETUP: begin
                w_state_nxt = S_WR_PULSE;
                w_cnt_nxt   = CNT_W'(WR_PULSE_CYCLES - 1);
            end
            S_WR_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WR_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_WR_HOLD: begin
                w_state_nxt = S_WR_SETTLE;
                w_cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
            end
            // By the last settle cycle the synchronized flags reflect pin
            // values from after the wrn rising edge, so they can be trusted.
            S_WR_SETTLE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (w_tx_ready) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (w_tx_ready) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_RD_WAIT: begin
                if (r_dr_s) begin
                    w_state_nxt = S_RD_PULSE;
                    w_cnt_nxt   = CNT_W'(RD_PULSE_CYCLES - 1);
                end
            end
            S_RD_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = S_DONE;
                    w_rd_data_nxt = bus_in;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rd_data  = r_rd_data;
    assign busy     = r_busy;
    assign done     = r_done;
    assign tx_ready = w_tx_ready;
    assign rx_ready = r_dr_s;
    assign rdn      = r_rdn;
    assign wrn      = r_wrn;
    assign bus_oe   = r_bus_oe;
    assign bus_out  = r_bus_out;

endmodule
